adc_multich_trig_capture: RTL and testbench

Multi-channel triggered capture buffer for AD9228 deserialized sample words; supersedes the single-channel free-running FIFO path. It sits after the per-channel deserializers in the main_ADC IP and takes one NUM_CH-wide frame per sample_valid. It keeps a circular pre-trigger history, triggers on software, external or per-channel level-crossing events, and captures a programmable post-trigger window. The frozen record is then read out in chronological order on the same clock.

---
 rtl/adc_multich_trig_capture.sv | 242 ++++++++++++++++++++++++
 tb/tb_adc_multich_trig_capture.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_multich_trig_capture.sv
// Multi-channel triggered capture buffer. A ring of frames keeps the pre-trigger
// history. A software, external or level-crossing trigger then starts the post-trigger
// window. The frozen record is read out oldest-first on the same clock.
module adc_multich_trig_capture #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH),
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int FW        = NUM_CH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sample_valid,
    input  logic [FW-1:0]         sample_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [AW-1:0]         pre_samples,
    input  logic [AW-1:0]         post_samples,
    input  logic [1:0]            trig_src,
    input  logic [CW-1:0]         trig_ch,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_ext,
    input  logic                  trig_sw,
    input  logic                  rd_en,
    output logic [FW-1:0]         rd_dout,
    output logic                  rd_valid,
    output logic [AW:0]           words_left,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    typedef enum logic [2:0] {StIdle, StPrefill, StArmed, StPost, StDone} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         trig_addr_q, trig_addr_d;
    logic [AW-1:0]         pre_q, pre_d;
    logic [AW-1:0]         post_q, post_d;
    logic [1:0]            src_q, src_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [DATA_WIDTH-1:0] level_q, level_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_ok_q, prev_ok_d;
    logic                  sw_pend_q, sw_pend_d;
    logic                  trig_q, trig_d;
    logic [AW:0]           words_q, words_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [FW-1:0]         rd_dout_q;

    logic [DATA_WIDTH-1:0] cur;
    logic [AW-1:0]         post_limit, post_clamped;
    logic                  level_hit, fire, wr_en, rd_fire;

    logic [FW-1:0] mem [DEPTH];

    // Select the level-trigger channel from the incoming frame.
    always_comb begin
        cur = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CW'(k)) cur = sample_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Post window is clamped so the record never exceeds DEPTH frames.
    assign post_limit   = AW'(DEPTH - 1) - pre_samples;
    assign post_clamped = (post_samples > post_limit) ? post_limit : post_samples;

    assign level_hit = src_q[1] && prev_ok_q && (prev_q < level_q) && (level_q <= cur);
    assign fire      = sw_pend_q || trig_sw || (src_q[0] && trig_ext) || level_hit;
    assign wr_en     = sample_valid &&
                       (state_q == StPrefill || state_q == StArmed || state_q == StPost);
    assign rd_fire   = (state_q == StDone) && rd_en && (words_q != '0) && !abort;

    // Capture memory write; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q] <= sample_data;
    end

    // Readout data register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_dout_q <= '0;
        end else if (rd_fire) begin
            rd_dout_q <= mem[rptr_q];
        end
    end

    // Next-state logic for the capture FSM, pointers and counters.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        pre_d       = pre_q;
        post_d      = post_q;
        src_d       = src_q;
        ch_d        = ch_q;
        level_d     = level_q;
        prev_d      = prev_q;
        prev_ok_d   = prev_ok_q;
        sw_pend_d   = sw_pend_q;
        trig_d      = trig_q;
        words_d     = words_q;
        rd_valid_d  = 1'b0;

        if (wr_en) begin
            wptr_d    = wptr_q + AW'(1);
            prev_d    = cur;
            prev_ok_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (arm) begin
                    pre_d     = pre_samples;
                    post_d    = post_clamped;
                    src_d     = trig_src;
                    ch_d      = trig_ch;
                    level_d   = trig_level;
                    wptr_d    = '0;
                    cnt_d     = '0;
                    sw_pend_d = 1'b0;
                    prev_ok_d = 1'b0;
                    trig_d    = 1'b0;
                    state_d   = (pre_samples == '0) ? StArmed : StPrefill;
                end
            end
            StPrefill: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q + AW'(1) == pre_q) begin
                        cnt_d   = '0;
                        state_d = StArmed;
                    end
                end
            end
            StArmed: begin
                if (sample_valid) begin
                    if (fire) begin
                        trig_addr_d = wptr_q;
                        trig_d      = 1'b1;
                        sw_pend_d   = 1'b0;
                        cnt_d       = '0;
                        if (post_q == '0) begin
                            rptr_d  = wptr_q - pre_q;
                            words_d = {1'b0, pre_q} + {1'b0, post_q} + (AW+1)'(1);
                            state_d = StDone;
                        end else begin
                            state_d = StPost;
                        end
                    end
                end else if (trig_sw) begin
                    // Remember a software trigger that arrived between frames.
                    sw_pend_d = 1'b1;
                end
            end
            StPost: begin
                if (sample_valid) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q + AW'(1) == post_q) begin
                        rptr_d  = trig_addr_q - pre_q;
                        words_d = {1'b0, pre_q} + {1'b0, post_q} + (AW+1)'(1);
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (rd_fire) begin
                    rptr_d     = rptr_q + AW'(1);
                    words_d    = words_q - (AW+1)'(1);
                    rd_valid_d = 1'b1;
                    if (words_q == (AW+1)'(1)) begin
                        state_d = StIdle;
                        trig_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over everything; memory is left untouched.
        if (abort) begin
            state_d    = StIdle;
            words_d    = '0;
            trig_d     = 1'b0;
            sw_pend_d  = 1'b0;
            rd_valid_d = 1'b0;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            src_q       <= '0;
            ch_q        <= '0;
            level_q     <= '0;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            sw_pend_q   <= 1'b0;
            trig_q      <= 1'b0;
            words_q     <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            src_q       <= src_d;
            ch_q        <= ch_d;
            level_q     <= level_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            sw_pend_q   <= sw_pend_d;
            trig_q      <= trig_d;
            words_q     <= words_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_dout    = rd_dout_q;
    assign rd_valid   = rd_valid_q;
    assign words_left = words_q;
    assign busy       = (state_q != StIdle);
    assign triggered  = trig_q;
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_adc_multich_trig_capture.sv
// Bench for adc_multich_trig_capture: a frame-history reference model checked every
// cycle, directed scenarios pinned with literal record contents, and random traffic.
module tb_adc_multich_trig_capture;

    localparam int NCH = 4;
    localparam int DW  = 12;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int FW  = NCH * DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          sample_valid = 1'b0;
    logic [FW-1:0] sample_data = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] pre_samples = '0;
    logic [AW-1:0] post_samples = '0;
    logic [1:0]    trig_src = '0;
    logic [1:0]    trig_ch = '0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_ext = 1'b0;
    logic          trig_sw = 1'b0;
    logic          rd_en = 1'b0;
    logic [FW-1:0] rd_dout;
    logic          rd_valid;
    logic [AW:0]   words_left;
    logic          busy;
    logic          triggered;
    logic          done;

    adc_multich_trig_capture #(
        .NUM_CH     (NCH),
        .DATA_WIDTH (DW),
        .DEPTH      (DEP)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .arm          (arm),
        .abort        (abort),
        .pre_samples  (pre_samples),
        .post_samples (post_samples),
        .trig_src     (trig_src),
        .trig_ch      (trig_ch),
        .trig_level   (trig_level),
        .trig_ext     (trig_ext),
        .trig_sw      (trig_sw),
        .rd_en        (rd_en),
        .rd_dout      (rd_dout),
        .rd_valid     (rd_valid),
        .words_left   (words_left),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 collecting before trigger, 2 collecting after trigger, 3 record ready
    int            m_phase;
    logic [FW-1:0] hist[$];
    logic [FW-1:0] rec[$];
    int            m_pre, m_post, m_trig_i, m_ch;
    logic [1:0]    m_src;
    logic [DW-1:0] m_level;
    bit            m_swp, m_trig, m_rdv;
    logic [FW-1:0] m_dout;

    function automatic logic [DW-1:0] chan(input logic [FW-1:0] f, input int c);
        return f[c*DW +: DW];
    endfunction

    task automatic m_reset();
        m_phase = 0;
        rec.delete();
        m_swp   = 1'b0;
        m_trig  = 1'b0;
        m_rdv   = 1'b0;
        m_dout  = '0;
    endtask

    task automatic m_finish();
        rec.delete();
        for (int j = m_trig_i - m_pre; j <= m_trig_i + m_post; j++) rec.push_back(hist[j]);
        m_phase = 3;
    endtask

    task automatic m_step();
        int  i;
        bit  hit;
        m_rdv = 1'b0;
        if (abort) begin
            m_phase = 0;
            rec.delete();
            m_trig = 1'b0;
            m_swp  = 1'b0;
        end else if (m_phase == 0) begin
            if (arm) begin
                m_pre   = int'(pre_samples);
                m_post  = int'(post_samples);
                if (m_post > DEP - 1 - m_pre) m_post = DEP - 1 - m_pre;
                m_src   = trig_src;
                m_ch    = int'(trig_ch);
                m_level = trig_level;
                hist.delete();
                m_swp   = 1'b0;
                m_trig  = 1'b0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (sample_valid) begin
                i   = hist.size();
                hit = 1'b0;
                // Frames with index below pre are the prefill; they cannot trigger.
                if (i >= m_pre) begin
                    hit = m_swp || trig_sw || (m_src[0] && trig_ext);
                    if (m_src[1] && i > 0 && chan(hist[i-1], m_ch) < m_level &&
                        m_level <= chan(sample_data, m_ch)) hit = 1'b1;
                end
                hist.push_back(sample_data);
                if (hit) begin
                    m_trig   = 1'b1;
                    m_swp    = 1'b0;
                    m_trig_i = i;
                    if (m_post == 0) m_finish();
                    else m_phase = 2;
                end
            end else if (hist.size() >= m_pre && trig_sw) begin
                m_swp = 1'b1;
            end
        end else if (m_phase == 2) begin
            if (sample_valid) begin
                hist.push_back(sample_data);
                if (hist.size() - 1 - m_trig_i == m_post) m_finish();
            end
        end else begin
            if (rd_en && rec.size() > 0) begin
                m_dout = rec.pop_front();
                m_rdv  = 1'b1;
                if (rec.size() == 0) begin
                    m_phase = 0;
                    m_trig  = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rstn) m_reset();
        else m_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic [FW-1:0] got[$];
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("done", 64'(done), 64'(m_phase == 3));
            chk("triggered", 64'(triggered), 64'(m_trig));
            chk("words_left", 64'(words_left), (m_phase == 3) ? 64'(rec.size()) : 64'd0);
            chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
            chk("rd_dout", 64'(rd_dout), 64'(m_dout));
        end
        if (rd_valid) got.push_back(rd_dout);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ramp on all channels; 1: ch2 ramps from 0x7FE; 2: ch2 constant 0x900;
    // 3: ch2 falls from 0x900. Channels 0,1,3 always carry the frame index.
    function automatic logic [FW-1:0] mk(input int mode, input int n);
        logic [DW-1:0] v, c2;
        v  = DW'(n);
        c2 = v;
        if (mode == 1) c2 = DW'(12'h7FE + n);
        if (mode == 2) c2 = 12'h900;
        if (mode == 3) c2 = DW'(12'h900 - 16 * n);
        return {v, c2, v, v};
    endfunction

    task automatic do_arm(input int pre, input int post, input int src, input int ch,
                          input int lvl);
        pre_samples  = AW'(pre);
        post_samples = AW'(post);
        trig_src     = 2'(src);
        trig_ch      = 2'(ch);
        trig_level   = DW'(lvl);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic feed(input string name, input int mode, input int sw_at, input int arm_at,
                        input int count, input bit until_done);
        for (int n = 0; n < count; n++) begin
            sample_valid = 1'b1;
            sample_data  = mk(mode, n);
            trig_sw      = (n == sw_at);
            arm          = (n == arm_at);
            if (n == arm_at) begin
                pre_samples  = '0;
                post_samples = '0;
            end
            tick();
            if (until_done && done) break;
        end
        sample_valid = 1'b0;
        trig_sw      = 1'b0;
        arm          = 1'b0;
        if (until_done) chk({name, "_done_timeout"}, 64'(done), 64'd1);
    endtask

    task automatic read_all(input string name);
        got.delete();
        rd_en = 1'b1;
        for (int c = 0; c < 3 * DEP; c++) begin
            tick();
            if (!busy) break;
        end
        rd_en = 1'b0;
        chk({name, "_read_timeout"}, 64'(busy), 64'd0);
        tick();
    endtask

    // Check the collected readout against a literal ramp first..first+count-1 (channel 0).
    task automatic chk_rec(input string name, input int first, input int count);
        chk({name, "_len"}, 64'(got.size()), 64'(count));
        for (int i = 0; i < got.size() && i < count; i++)
            chk({name, "_frame"}, 64'(got[i][DW-1:0]), 64'(first + i));
    endtask

    task automatic basic(input string name);
        do_arm(4, 3, 0, 0, 0);
        feed(name, 0, 10, -1, 60, 1'b1);
        chk({name, "_words"}, 64'(words_left), 64'd8);
        read_all(name);
        chk_rec(name, 6, 8);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [DW-1:0] rv();
        return DW'(12'h7E8 + $urandom_range(0, 48));
    endfunction

    initial begin
        m_reset();
        #2 rstn = 1'b0;
        m_reset();
        chk_en = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_words", 64'(words_left), 64'd0);
        chk("reset_dout", 64'(rd_dout), 64'd0);

        // Basic software-triggered capture.
        basic("basic");

        // Level trigger on channel 2 rising through 0x800.
        do_arm(2, 1, 2, 2, 12'h800);
        feed("level", 1, -1, -1, 60, 1'b1);
        read_all("level");
        chk_rec("level", 0, 4);
        if (got.size() > 2) chk("level_trig_frame", 64'(got[2][35:24]), 64'h800);

        // Constant above level and a falling input never trigger.
        do_arm(2, 1, 2, 2, 12'h800);
        feed("const", 2, -1, -1, 30, 1'b0);
        chk("const_no_trig", 64'(triggered), 64'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        do_arm(2, 1, 2, 2, 12'h800);
        feed("fall", 3, -1, -1, 30, 1'b0);
        chk("fall_no_trig", 64'(triggered), 64'd0);
        abort = 1'b1; tick(); abort = 1'b0;

        // Ring wraps several times before the trigger.
        do_arm(5, 4, 0, 0, 0);
        feed("wrap", 0, 40, -1, 80, 1'b1);
        chk("wrap_words", 64'(words_left), 64'd10);
        read_all("wrap");
        chk_rec("wrap", 35, 10);

        // Post window clamp; external trigger held through prefill.
        trig_ext = 1'b1;
        do_arm(10, 15, 1, 0, 0);
        feed("clamp", 0, -1, -1, 60, 1'b1);
        trig_ext = 1'b0;
        chk("clamp_words", 64'(words_left), 64'd16);
        read_all("clamp");
        chk_rec("clamp", 0, 16);

        // Single-frame record, then reads with nothing left.
        do_arm(0, 0, 0, 0, 0);
        feed("single", 0, 3, -1, 20, 1'b1);
        chk("single_words", 64'(words_left), 64'd1);
        read_all("single");
        chk_rec("single", 3, 1);
        rd_en = 1'b1;
        tick(); tick();
        chk("empty_rd_valid", 64'(rd_valid), 64'd0);
        rd_en = 1'b0;

        // arm during the post window is ignored.
        do_arm(2, 6, 0, 0, 0);
        feed("armpost", 0, 5, 7, 60, 1'b1);
        read_all("armpost");
        chk_rec("armpost", 3, 9);

        // Abort in the post window.
        do_arm(3, 8, 0, 0, 0);
        feed("abort", 0, 5, -1, 8, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_trig", 64'(triggered), 64'd0);
        chk("abort_words", 64'(words_left), 64'd0);

        // Reset while armed.
        do_arm(2, 2, 0, 0, 0);
        feed("rst", 0, -1, -1, 4, 1'b0);
        chk("rst_busy_before", 64'(busy), 64'd1);
        rstn = 1'b0;
        m_reset();
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dout", 64'(rd_dout), 64'd0);
        tick(); tick();
        rstn = 1'b1;
        tick();
        basic("after_rst");

        // Random traffic against the model.
        for (int it = 0; it < 25; it++) begin
            do_arm(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'(12'h7F0 + $urandom_range(0, 32)));
            for (int c = 0; c < 400; c++) begin
                sample_valid = ($urandom_range(0, 9) < 7);
                sample_data  = {rv(), rv(), rv(), rv()};
                trig_ext     = ($urandom_range(0, 19) == 0);
                trig_sw      = ($urandom_range(0, 39) == 0);
                rd_en        = ($urandom_range(0, 1) == 1);
                arm          = ($urandom_range(0, 49) == 0);
                abort        = ($urandom_range(0, 199) == 0);
                tick();
                if (m_phase == 0) break;
            end
            sample_valid = 1'b0;
            trig_ext = 1'b0;
            trig_sw  = 1'b0;
            rd_en    = 1'b0;
            arm      = 1'b0;
            abort    = 1'b1;
            tick();
            abort    = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
